stream_byte_source: RTL

//   Upstream feeder for the sample_module byte stream. Accepts 32-bit words on a

---
 rtl/stream_byte_source.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stream_byte_source.sv
// ---------------------------------------------------------------------------
// stream_byte_source : 32-bit word FIFO feeding an LSB-first byte serializer
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module stream_byte_source #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     word_in_valid,
  output logic                     word_in_ready,
  input  logic [31:0]              word_in_data,
  output logic                     stream_out_valid,
  input  logic                     stream_out_ready,
  output logic [7:0]               stream_out_data,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         bytes_sent
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SEND = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       hold_q, hold_d;
  logic              valid_q, valid_d;
  logic [7:0]        data_q, data_d;
  logic [AW-1:0]     wr_q, wr_d;
  logic [AW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic              rdy_en_q;
  logic [31:0]       mem_q [DEPTH];

  logic              push;
  logic              pop;
  logic              fire;
  logic              has_word;
  logic [31:0]       head;

  // Ready is held low during reset and for the release edge itself.
  assign word_in_ready    = rdy_en_q & (cnt_q != CW'(DEPTH));
  assign stream_out_valid = valid_q;
  assign stream_out_data  = data_q;
  assign fifo_count       = cnt_q;
  assign bytes_sent       = sent_q;

  assign fire     = valid_q & stream_out_ready;
  assign has_word = (cnt_q != '0);
  assign head     = mem_q[rd_q];
  assign push     = word_in_valid & word_in_ready & ~clear;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    data_d  = data_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
    pop     = 1'b0;

    // The output handshake still counts on a clearing edge.
    if (fire) begin
      sent_d = sent_q + CNT_W'(1);
    end

    if (clear) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      idx_d   = 2'd0;
      cnt_d   = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (has_word) begin
            pop = 1'b1;
          end
        end
        S_SEND: begin
          if (fire) begin
            if (idx_q != 2'd3) begin
              idx_d  = idx_q + 2'd1;
              data_d = hold_q[8*idx_d +: 8];
            end else if (has_word) begin
              pop = 1'b1;
            end else begin
              state_d = S_IDLE;
              valid_d = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Back-to-back words reload the hold register without a bubble.
      if (pop) begin
        hold_d  = head;
        data_d  = head[7:0];
        idx_d   = 2'd0;
        valid_d = 1'b1;
        state_d = S_SEND;
        rd_d    = rd_q + AW'(1);
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      hold_q   <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      sent_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      hold_q   <= hold_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      sent_q   <= sent_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= word_in_data;
    end
  end

endmodule

`default_nettype wire
